// File: rtl/ex_pkg.sv
// ============================================================================
// Module      : ex_pkg
// Description : ALU opcodes, HI/LO write masks and divider state encoding
//               shared by the MIPS32 execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_pkg;

    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_ADDU  = 5'd2;
    localparam logic [4:0] ALU_SUB   = 5'd3;
    localparam logic [4:0] ALU_SUBU  = 5'd4;
    localparam logic [4:0] ALU_AND   = 5'd5;
    localparam logic [4:0] ALU_OR    = 5'd6;
    localparam logic [4:0] ALU_XOR   = 5'd7;
    localparam logic [4:0] ALU_NOR   = 5'd8;
    localparam logic [4:0] ALU_SLL   = 5'd9;
    localparam logic [4:0] ALU_SRL   = 5'd10;
    localparam logic [4:0] ALU_SRA   = 5'd11;
    localparam logic [4:0] ALU_SLT   = 5'd12;
    localparam logic [4:0] ALU_SLTU  = 5'd13;
    localparam logic [4:0] ALU_LUI   = 5'd14;
    localparam logic [4:0] ALU_MULT  = 5'd15;
    localparam logic [4:0] ALU_MULTU = 5'd16;
    localparam logic [4:0] ALU_DIV   = 5'd17;
    localparam logic [4:0] ALU_DIVU  = 5'd18;
    localparam logic [4:0] ALU_MFHI  = 5'd19;
    localparam logic [4:0] ALU_MFLO  = 5'd20;
    localparam logic [4:0] ALU_MTHI  = 5'd21;
    localparam logic [4:0] ALU_MTLO  = 5'd22;

    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_LO   = 2'b01;
    localparam logic [1:0] HILO_HI   = 2'b10;
    localparam logic [1:0] HILO_BOTH = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : Iterative restoring divider (one quotient bit per cycle) with
//               sign handling and divide-by-zero shortcut.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
    import ex_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_STEPS);

    div_state_t        state, state_next;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] quo, rem, dsr;
    logic              neg_q, neg_r;

    logic              a_neg, b_neg, div_zero;
    logic [DATA_W-1:0] abs_a, abs_b;
    logic [DATA_W:0]   shifted, trial;

    assign a_neg    = signed_op & dividend[DATA_W-1];
    assign b_neg    = signed_op & divisor[DATA_W-1];
    assign abs_a    = a_neg ? -dividend : dividend;
    assign abs_b    = b_neg ? -divisor  : divisor;
    assign div_zero = (divisor == '0);

    // Partial remainder pulls in the next dividend bit; a non-negative trial keeps the subtraction.
    assign shifted  = {rem, quo[DATA_W-1]};
    assign trial    = shifted - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start) state_next = div_zero ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (count == CNT_W'(DIV_STEPS - 1)) state_next = DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            quo   <= '0;
            rem   <= '0;
            dsr   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            count <= '0;
            dsr   <= abs_b;
            if (div_zero) begin
                quo   <= '1;
                rem   <= dividend;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                quo   <= abs_a;
                rem   <= '0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
            end
        end else if (state == DIV_BUSY) begin
            count <= count + 1'b1;
            if (!trial[DATA_W]) begin
                rem <= trial[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
                rem <= shifted[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign busy      = (state == DIV_BUSY);
    assign done      = (state == DIV_DONE);
    assign quotient  = neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module      : ex_stage
// Description : MIPS32 execute stage: single-cycle ALU/shift/multiply plus an
//               iterative divider that stalls the pipeline. Optional macro
//               EX_OVF_EN enables signed ADD/SUB overflow trapping (ovf_o).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ALUop_i,
    input  logic [DATA_W-1:0] oprand1_i,
    input  logic [DATA_W-1:0] oprand2_i,
    input  logic [4:0]        writeAddr_i,
    input  logic              writeEnable_i,
    input  logic [1:0]        writeHILO_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] writeData_o,
    output logic [4:0]        writeAddr_o,
    output logic              writeEnable_o,
    output logic [1:0]        writeHILO_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stall_req_o
`ifdef EX_OVF_EN
    ,
    output logic              ovf_o
`endif
);

    logic              is_div, div_busy, div_done, stall;
    logic [DATA_W-1:0] div_q, div_r, sum, diff;
    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic [4:0]        shamt;

    assign is_div = is_div_op(ALUop_i);
    assign shamt  = oprand1_i[4:0];
    assign sum    = oprand1_i + oprand2_i;
    assign diff   = oprand1_i - oprand2_i;
    assign prod_s = {{DATA_W{oprand1_i[DATA_W-1]}}, oprand1_i} * {{DATA_W{oprand2_i[DATA_W-1]}}, oprand2_i};
    assign prod_u = {{DATA_W{1'b0}}, oprand1_i} * {{DATA_W{1'b0}}, oprand2_i};

    // A divide waiting in IDLE already stalls so the operands stay put while it is latched.
    assign stall  = !rst && (div_busy || (is_div && !div_done));

    div_unit #(
        .DATA_W    (DATA_W),
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div && !rst),
        .signed_op (ALUop_i == ALU_DIV),
        .dividend  (oprand1_i),
        .divisor   (oprand2_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

`ifdef EX_OVF_EN
    logic add_ovf, sub_ovf, ovf;
    assign add_ovf = (oprand1_i[DATA_W-1] == oprand2_i[DATA_W-1]) && (sum[DATA_W-1]  != oprand1_i[DATA_W-1]);
    assign sub_ovf = (oprand1_i[DATA_W-1] != oprand2_i[DATA_W-1]) && (diff[DATA_W-1] != oprand1_i[DATA_W-1]);
    assign ovf_o   = ovf;
`endif

    always_comb begin
        writeData_o   = '0;
        writeEnable_o = 1'b0;
        writeHILO_o   = HILO_NONE;
        hi_o          = '0;
        lo_o          = '0;
        writeAddr_o   = rst ? 5'd0 : writeAddr_i;
`ifdef EX_OVF_EN
        ovf           = 1'b0;
`endif
        case (ALUop_i)
            ALU_ADD: begin
                writeData_o   = sum;
                writeEnable_o = writeEnable_i;
`ifdef EX_OVF_EN
                ovf           = add_ovf;
                writeEnable_o = writeEnable_i & ~add_ovf;
`endif
            end
            ALU_SUB: begin
                writeData_o   = diff;
                writeEnable_o = writeEnable_i;
`ifdef EX_OVF_EN
                ovf           = sub_ovf;
                writeEnable_o = writeEnable_i & ~sub_ovf;
`endif
            end
            ALU_ADDU: begin writeData_o = sum;  writeEnable_o = writeEnable_i; end
            ALU_SUBU: begin writeData_o = diff; writeEnable_o = writeEnable_i; end
            ALU_AND:  begin writeData_o = oprand1_i & oprand2_i;    writeEnable_o = writeEnable_i; end
            ALU_OR:   begin writeData_o = oprand1_i | oprand2_i;    writeEnable_o = writeEnable_i; end
            ALU_XOR:  begin writeData_o = oprand1_i ^ oprand2_i;    writeEnable_o = writeEnable_i; end
            ALU_NOR:  begin writeData_o = ~(oprand1_i | oprand2_i); writeEnable_o = writeEnable_i; end
            ALU_SLL:  begin writeData_o = oprand2_i << shamt;  writeEnable_o = writeEnable_i; end
            ALU_SRL:  begin writeData_o = oprand2_i >> shamt;  writeEnable_o = writeEnable_i; end
            ALU_SRA:  begin writeData_o = $signed(oprand2_i) >>> shamt; writeEnable_o = writeEnable_i; end
            ALU_SLT:  begin writeData_o = {{(DATA_W-1){1'b0}}, $signed(oprand1_i) < $signed(oprand2_i)}; writeEnable_o = writeEnable_i; end
            ALU_SLTU: begin writeData_o = {{(DATA_W-1){1'b0}}, oprand1_i < oprand2_i}; writeEnable_o = writeEnable_i; end
            ALU_LUI:  begin writeData_o = {oprand2_i[15:0], 16'h0000}; writeEnable_o = writeEnable_i; end
            ALU_MFHI: begin writeData_o = hi_i; writeEnable_o = writeEnable_i; end
            ALU_MFLO: begin writeData_o = lo_i; writeEnable_o = writeEnable_i; end
            ALU_MULT: begin
                hi_o        = prod_s[2*DATA_W-1:DATA_W];
                lo_o        = prod_s[DATA_W-1:0];
                writeHILO_o = HILO_BOTH;
            end
            ALU_MULTU: begin
                hi_o        = prod_u[2*DATA_W-1:DATA_W];
                lo_o        = prod_u[DATA_W-1:0];
                writeHILO_o = HILO_BOTH;
            end
            ALU_MTHI: begin hi_o = oprand1_i; writeHILO_o = HILO_HI; end
            ALU_MTLO: begin lo_o = oprand1_i; writeHILO_o = HILO_LO; end
            ALU_DIV, ALU_DIVU: begin
                if (div_done) begin
                    hi_o        = div_r;
                    lo_o        = div_q;
                    writeHILO_o = HILO_BOTH;
                end
            end
            default: ;
        endcase

        // Held instructions must not commit more than once while the divider runs.
        if (rst || stall) begin
            writeData_o   = '0;
            writeEnable_o = 1'b0;
            writeHILO_o   = HILO_NONE;
            hi_o          = '0;
            lo_o          = '0;
`ifdef EX_OVF_EN
            ovf           = 1'b0;
`endif
        end
    end

    assign stall_req_o = stall;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage: directed cases plus random
//               operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  op;
    logic [31:0] a, b, hi_in, lo_in;
    logic [4:0]  waddr;
    logic        wen;
    logic [1:0]  hilo_in;
    logic [31:0] wdata, hi_out, lo_out;
    logic [4:0]  waddr_out;
    logic        we_out, stall;
    logic [1:0]  mask_out;
    logic        ovf_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ALUop_i       (op),
        .oprand1_i     (a),
        .oprand2_i     (b),
        .writeAddr_i   (waddr),
        .writeEnable_i (wen),
        .writeHILO_i   (hilo_in),
        .hi_i          (hi_in),
        .lo_i          (lo_in),
        .writeData_o   (wdata),
        .writeAddr_o   (waddr_out),
        .writeEnable_o (we_out),
        .writeHILO_o   (mask_out),
        .hi_o          (hi_out),
        .lo_o          (lo_out),
        .stall_req_o   (stall)
`ifdef EX_OVF_EN
        ,
        .ovf_o         (ovf_out)
`endif
    );

`ifndef EX_OVF_EN
    assign ovf_out = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference for every non-divide operation, in plain integer arithmetic.
    function automatic void model(input logic [4:0] o, input logic [31:0] x, y, h, l, input logic en,
                                  output logic [31:0] wd, output logic we, output logic [1:0] m,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ov);
        longint sx, sy, s, d;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        wd = 0; we = 0; m = 0; eh = 0; el = 0; ov = 0;
        case (o)
            ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU: begin
                s  = (o == ALU_ADD || o == ALU_ADDU) ? sx + sy : sx - sy;
                wd = s[31:0];
                we = en;
`ifdef EX_OVF_EN
                if ((o == ALU_ADD || o == ALU_SUB) && s != longint'($signed(s[31:0]))) begin
                    ov = 1; we = 0;
                end
`endif
            end
            ALU_AND:  begin wd = x & y;    we = en; end
            ALU_OR:   begin wd = x | y;    we = en; end
            ALU_XOR:  begin wd = x ^ y;    we = en; end
            ALU_NOR:  begin wd = ~(x | y); we = en; end
            ALU_SLL:  begin p = {32'd0, y} * (64'd1 << x[4:0]); wd = p[31:0]; we = en; end
            ALU_SRL:  begin wd = y / (32'd1 << x[4:0]); we = en; end
            ALU_SRA:  begin
                d = longint'(64'd1 << x[4:0]);
                s = sy / d;
                if (sy < 0 && (sy % d) != 0) s = s - 1;
                wd = s[31:0]; we = en;
            end
            ALU_SLT:  begin wd = (sx < sy) ? 1 : 0; we = en; end
            ALU_SLTU: begin wd = (x < y) ? 1 : 0;   we = en; end
            ALU_LUI:  begin wd = y[15:0] * 32'h10000; we = en; end
            ALU_MULT: begin s = sx * sy; eh = s[63:32]; el = s[31:0]; m = 2'b11; end
            ALU_MULTU: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; m = 2'b11; end
            ALU_MFHI: begin wd = h; we = en; end
            ALU_MFLO: begin wd = l; we = en; end
            ALU_MTHI: begin eh = x; m = 2'b10; end
            ALU_MTLO: begin el = x; m = 2'b01; end
            default: ;
        endcase
    endfunction

    function automatic void div_model(input logic [4:0] o, input logic [31:0] x, y,
                                      output logic [31:0] q, output logic [31:0] r);
        longint sx, sy, t;
        if (y == 0) begin
            q = 32'hFFFFFFFF; r = x;
        end else if (o == ALU_DIVU) begin
            q = x / y; r = x % y;
        end else begin
            sx = $signed(x); sy = $signed(y);
            t = sx / sy; q = t[31:0];
            t = sx % sy; r = t[31:0];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] o, input logic [31:0] x, y);
        op = o; a = x; b = y;
    endtask

    task automatic check_comb(input string tag);
        logic [31:0] ewd, eh, el;
        logic        ewe, eov;
        logic [1:0]  em;
        model(op, a, b, hi_in, lo_in, wen, ewd, ewe, em, eh, el, eov);
        @(negedge clk);
        chk({tag, ".data"},  wdata,     ewd);
        chk({tag, ".we"},    we_out,    ewe);
        chk({tag, ".mask"},  mask_out,  em);
        chk({tag, ".hi"},    hi_out,    eh);
        chk({tag, ".lo"},    lo_out,    el);
        chk({tag, ".addr"},  waddr_out, waddr);
        chk({tag, ".stall"}, stall,     1'b0);
        chk({tag, ".ovf"},   ovf_out,   eov);
        step();
    endtask

    task automatic do_div(input string tag, input logic [4:0] o, input logic [31:0] x, y);
        logic [31:0] eq, er;
        int n;
        drive(o, x, y);
        div_model(o, x, y, eq, er);
        n = (y == 0) ? 1 : 33;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, ".stall"}, stall,    1'b1);
            chk({tag, ".swe"},   we_out,   1'b0);
            chk({tag, ".smask"}, mask_out, 2'b00);
            step();
        end
        @(negedge clk);
        chk({tag, ".dstall"}, stall,    1'b0);
        chk({tag, ".dmask"},  mask_out, 2'b11);
        chk({tag, ".dwe"},    we_out,   1'b0);
        chk({tag, ".quo"},    lo_out,   eq);
        chk({tag, ".rem"},    hi_out,   er);
        step();
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] corner [5];
        corner[0] = 32'h80000000; corner[1] = 32'h7FFFFFFF; corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h00000000; corner[4] = 32'h00000001;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [4:0] ro;
        rst = 1'b1; hilo_in = 2'b00; waddr = 5'd7; wen = 1'b1;
        hi_in = 32'h1234_5678; lo_in = 32'h9ABC_DEF0;
        drive(ALU_ADDU, 32'h11, 32'h22);
        @(negedge clk);
        chk("rst.stall", stall,     1'b0);
        chk("rst.data",  wdata,     32'h0);
        chk("rst.we",    we_out,    1'b0);
        chk("rst.mask",  mask_out,  2'b00);
        chk("rst.addr",  waddr_out, 5'd0);
        step();
        rst = 1'b0;

        drive(ALU_ADDU, 32'hFFFFFFFF, 32'h1);          check_comb("addu_wrap");
        drive(ALU_ADD,  32'h7FFFFFFF, 32'h1);          check_comb("add_ovf");
        drive(ALU_SUB,  32'h80000000, 32'h1);          check_comb("sub_ovf");
        drive(ALU_SRA,  32'd4, 32'h80000000);          check_comb("sra");
        drive(ALU_SLT,  32'hFFFFFFFF, 32'h1);          check_comb("slt");
        drive(ALU_SLTU, 32'hFFFFFFFF, 32'h1);          check_comb("sltu");
        drive(ALU_MULT, 32'hFFFFFFFE, 32'h3);          check_comb("mult");
        drive(ALU_LUI,  32'h0, 32'hDEAD_BEEF);         check_comb("lui");
        drive(ALU_MFHI, 32'h0, 32'h0);                 check_comb("mfhi");
        drive(ALU_MTLO, 32'hCAFE_F00D, 32'h0);         check_comb("mtlo");
        drive(5'd27,    32'h5, 32'h6);                 check_comb("unknown");

        do_div("div_neg",  ALU_DIV,  32'hFFFFFFF9, 32'd2);
        do_div("divu",     ALU_DIVU, 32'd100, 32'd7);
        do_div("divu_z",   ALU_DIVU, 32'd5, 32'd0);
        do_div("divu_b2b", ALU_DIVU, 32'hFFFF_FFF0, 32'd3);
        do_div("div_min",  ALU_DIV,  32'h80000000, 32'hFFFFFFFF);

        drive(ALU_DIVU, 32'd1000, 32'd9);
        for (int i = 0; i < 11; i++) step();
        @(negedge clk);
        chk("mid.busy", stall, 1'b1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid.rst_stall", stall,    1'b0);
        chk("mid.rst_mask",  mask_out, 2'b00);
        step();
        rst = 1'b0;
        drive(ALU_NOP, 32'd0, 32'd0);
        @(negedge clk);
        chk("mid.after_stall", stall,    1'b0);
        chk("mid.after_mask",  mask_out, 2'b00);
        step();
        do_div("div_after_rst", ALU_DIVU, 32'd9, 32'd3);

        for (int i = 0; i < 60; i++) begin
            do ro = 5'($urandom_range(0, 31)); while (is_div_op(ro));
            wen = 1'($urandom);
            waddr = 5'($urandom);
            hi_in = $urandom; lo_in = $urandom;
            drive(ro, rnd_val(), rnd_val());
            check_comb("rnd_alu");
        end
        wen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ro = $urandom_range(0, 1) ? ALU_DIV : ALU_DIVU;
            do_div("rnd_div", ro, rnd_val(), (i % 4 == 3) ? 32'd0 : ($urandom_range(0, 1) ? rnd_val() : 32'($urandom_range(1, 50))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the MIPS32 five-stage pipeline. Consumes the ID/EX pipeline register outputs (ALU op, two operands, destination, write enables, HI/LO write mask) and produces the result bundle for the EX/MEM register. Single-cycle ALU, shifter and multiplier operations complete combinationally in the same cycle. DIV/DIVU run on an iterative 32-step restoring divider that stalls the pipeline through stall_req.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
DIV_STEPS, 32, divider iterations; must equal DATA_W.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ALUop_i  in  5  operation code, encodings in ex_pkg
oprand1_i  in  32  operand 1 (rs, or shamt in [4:0] for shifts)
oprand2_i  in  32  operand 2 (rt or immediate)
writeAddr_i  in  5  GPR destination
writeEnable_i  in  1  GPR write request
writeHILO_i  in  2  HI/LO write mask from decode, bit1=HI, bit0=LO
hi_i  in  32  current HI, forwarded
lo_i  in  32  current LO, forwarded
writeData_o  out  32  GPR result
writeAddr_o  out  5  passthrough of writeAddr_i
writeEnable_o  out  1  GPR write enable
writeHILO_o  out  2  HI/LO write mask
hi_o  out  32  HI write value
lo_o  out  32  LO write value
stall_req_o  out  1  hold IF/ID/ID_EX; EX/MEM inserts bubble

Behaviour:
- Combinational ops, same cycle: ADD/ADDU/SUB/SUBU wrap mod 2^32. AND/OR/XOR/NOR. LUI gives {op2[15:0],16'h0}.
- SLL/SRL/SRA shift op2 by op1[4:0]. SLT is signed compare, SLTU unsigned; result is 0 or 1.
- MULT/MULTU: 64-bit product, hi_o=[63:32], lo_o=[31:0], writeHILO_o=2'b11, writeEnable_o=0.
- MFHI returns hi_i and MFLO returns lo_i. MTHI sets hi_o=op1 with mask 2'b10. MTLO sets lo_o=op1 with mask 2'b01.
- NOP or an unknown op: writeData_o=0, writeEnable_o=0, writeHILO_o=0.
- For non-HI/LO ops, hi_o, lo_o and writeHILO_o are all 0.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE to BUSY when ALUop_i is DIV or DIVU. In that same cycle it latches |op1| and |op2| (signed) or the raw values (unsigned), plus the quotient and remainder sign flags. Counter is set to 0 and stall_req_o=1.
  - BUSY performs one restoring step per cycle with stall_req_o=1. After step 31 it goes to DONE.
  - Divisor 0: IDLE goes directly to DONE next cycle. Quotient is 32'hFFFFFFFF and remainder is the dividend; no sign fixup.
  - DONE: stall_req_o=0. Sign fixup is applied: quotient is negated if the operand signs differ, remainder takes the dividend's sign.
  - DONE outputs lo_o=quotient, hi_o=remainder, writeHILO_o=2'b11, writeEnable_o=0. Next state is IDLE unconditionally.
  - If ALUop_i is not DIV/DIVU in DONE, the result is dropped and the mask is 0.
- Latency: DIV enters EX in cycle k. stall_req_o=1 for cycles k..k+32 and the result appears in cycle k+33. With divisor 0 the result appears in k+1.
- Back-to-back DIV: the second DIV starts in the IDLE cycle after DONE.
- While stalled, all GPR/HI/LO write outputs are forced to 0. This prevents duplicate commits.
- The divider's signed special case 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
- rst: FSM goes to IDLE, counter to 0, and stall_req_o to 0. All outputs are 0 in the reset cycle. This also applies to reset mid-division; the division is abandoned.

Optional Feature:
EX_OVF_EN
- Defined: a signed overflow on ADD or SUB forces writeEnable_o=0 (destination not written). Adds port ovf_o (out, 1), high that cycle.
- Undefined: ADD behaves as ADDU and SUB behaves as SUBU. No ovf_o port.

Decomposition:
- ex_pkg holds the ALU_* opcode localparams: NOP=0, ADD=1, ADDU=2, SUB=3, SUBU=4, AND=5, OR=6, XOR=7, NOR=8, SLL=9, SRL=10, SRA=11, SLT=12, SLTU=13, LUI=14, MULT=15, MULTU=16, DIV=17, DIVU=18, MFHI=19, MFLO=20, MTHI=21, MTLO=22.
- ex_pkg also holds the div FSM state encoding and HILO mask constants.
- Sub-module div_unit holds the FSM, counter and restoring datapath.
  - Ports: start, signed_op, dividend, divisor, busy, done, quotient, remainder.

Test Plan:
- ADDU 0xFFFFFFFF + 1: writeData_o=0 and writeEnable_o=1. ADD 0x7FFFFFFF + 1 with EX_OVF_EN: writeEnable_o=0 and ovf_o=1.
- SRA op1=4, op2=0x80000000 gives 0xF8000000. SLT -1 vs 1 gives 1; SLTU -1 vs 1 gives 0.
- MULT 0xFFFFFFFE × 3 gives hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, mask 2'b11.
- DIV -7 / 2: stall_req_o high for 33 cycles, then lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, mask 2'b11. DIVU 100/7 gives lo_o=14, hi_o=2.
- DIVU 5/0: one stall cycle, then lo_o=0xFFFFFFFF, hi_o=5. Back-to-back DIVU starts the cycle after DONE.
- rst at BUSY step 10: stall_req_o=0 the next cycle with no HI/LO write. A following DIVU 9/3 completes correctly (lo_o=3, hi_o=0).
